// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback pipeline register.
// Captures the function_unit result and flags, selects the writeback value,
// holds the {C,V,N,Z} status register and counts retired instructions.
// A single-entry valid/ready slot back-pressures the execute stage.
// Optional feature: define OVF_TRAP_EN to suppress overflowing register
// writes and raise a one-cycle trap pulse; otherwise trap is tied low.
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] fu_out,
  input  logic              fu_c,
  input  logic              fu_v,
  input  logic              fu_n,
  input  logic              fu_z,
  input  logic [DATA_W-1:0] dmem_data,
  input  logic [ADDR_W-1:0] da,
  input  logic              rw,
  input  logic [1:0]        md,
  input  logic              fl,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        status,
  output logic [CNT_W-1:0]  retired,
  output logic              trap
);

  typedef enum logic [1:0] {
    MD_FU   = 2'b00,
    MD_MEM  = 2'b01,
    MD_SLT  = 2'b10,
    MD_RSVD = 2'b11
  } md_e;

  logic              r_wb_valid;
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [3:0]        r_status;
  logic [CNT_W-1:0]  r_retired;

  logic              w_ex_ready;
  logic              w_accept;
  logic              w_retire;
  logic              w_ovf;
  logic              w_we_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  // The slot can take a new entry when empty or when its occupant leaves now.
  assign w_ex_ready = !r_wb_valid || wb_ready;
  // flush kills the incoming instruction, so it never counts as an accept.
  assign w_accept   = ex_valid && w_ex_ready && !flush;
  assign w_retire   = r_wb_valid && wb_ready;

`ifdef OVF_TRAP_EN
  assign w_ovf = fu_v && (md_e'(md) == MD_FU) && rw;
`else
  assign w_ovf = 1'b0;
`endif

  // Writeback value and write enable for the instruction being offered.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_data_nxt = '0;
    w_we_nxt   = rw && (da != '0) && !w_ovf;
    case (md_e'(md))
      MD_FU:   w_data_nxt = fu_out;
      MD_MEM:  w_data_nxt = dmem_data;
      // Upstream op is A-B; N^V is the signed less-than result.
      MD_SLT:  w_data_nxt[0] = fu_n ^ fu_v;
      default: w_we_nxt = 1'b0;
    endcase
  end

  // Writeback slot: flush empties it, accept loads it, bare retire drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
    end else if (w_accept) begin
      r_wb_valid <= 1'b1;
      r_wb_we    <= w_we_nxt;
      r_wb_addr  <= da;
      r_wb_data  <= w_data_nxt;
    end else if (w_retire) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
    end
  end

  // Status flags load at accept so the next instruction sees them early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
    end else if (w_accept && fl) begin
      r_status <= {fu_c, fu_v, fu_n, fu_z};
    end
  end

  // Retired counter wraps naturally; retires without a write still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

`ifdef OVF_TRAP_EN
  logic r_trap;

  // Trap pulses for one cycle alongside the overflowing entry's arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_accept && w_ovf;
    end
  end

  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

  assign ex_ready = w_ex_ready;
  assign wb_valid = r_wb_valid;
  assign wb_we    = r_wb_we;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;
  assign status   = r_status;
  assign retired  = r_retired;

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed plus randomized bench for ex_wb_stage.
// Operands A/B are generated and the function_unit result and flags are
// derived arithmetically; a behavioural model tracks the writeback slot.
// A small counter width is used so the retired counter wraps during the run.
module tb_ex_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic [DATA_W-1:0] fu_out = '0;
  logic              fu_c = 1'b0, fu_v = 1'b0, fu_n = 1'b0, fu_z = 1'b0;
  logic [DATA_W-1:0] dmem_data = '0;
  logic [ADDR_W-1:0] da = '0;
  logic              rw = 1'b0;
  logic [1:0]        md = 2'b00;
  logic              fl = 1'b0;
  logic              flush = 1'b0;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        status;
  logic [CNT_W-1:0]  retired;
  logic              trap;

  ex_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .fu_out(fu_out), .fu_c(fu_c), .fu_v(fu_v), .fu_n(fu_n), .fu_z(fu_z),
    .dmem_data(dmem_data), .da(da), .rw(rw), .md(md), .fl(fl), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .status(status), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference state: contents of the writeback slot and architectural state.
  bit                m_valid, m_we, m_trap;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [3:0]        m_status;
  logic [CNT_W-1:0]  m_retired;
  bit                tb_slt;   // signed A<B for the current subtract

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive function_unit outputs from an add or subtract of A and B.
  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input bit sub);
    logic [32:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else     r = {1'b0, a} + {1'b0, b};
    fu_out = r[31:0];
    fu_c   = r[32];
    fu_n   = r[31];
    fu_z   = (r[31:0] == 32'd0);
    fu_v   = sub ? ((a[31] != b[31]) && (r[31] != a[31]))
                 : ((a[31] == b[31]) && (r[31] != a[31]));
    tb_slt = sub && ($signed(a) < $signed(b));
  endtask

  task automatic model_clear();
    m_valid = 0; m_we = 0; m_trap = 0; m_addr = '0; m_data = '0;
    m_status = '0; m_retired = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid"},   wb_valid, m_valid);
    check({pfx, "_we"},      wb_we,    m_we);
    check({pfx, "_addr"},    wb_addr,  m_addr);
    check({pfx, "_data"},    wb_data,  m_data);
    check({pfx, "_status"},  status,   m_status);
    check({pfx, "_retired"}, retired,  m_retired);
    check({pfx, "_trap"},    trap,     m_trap);
  endtask

  // One clock: check ex_ready mid-cycle, advance the model, check outputs.
  task automatic step(input string pfx);
    bit ret, take, ovf;
    @(negedge clk);
    check({pfx, "_ex_ready"}, ex_ready, !m_valid || wb_ready);
    ret  = m_valid && wb_ready;
    take = ex_valid && (!m_valid || wb_ready) && !flush;
`ifdef OVF_TRAP_EN
    ovf  = fu_v && (md == 2'b00) && rw;
`else
    ovf  = 0;
`endif
    @(posedge clk);
    #1;
    if (ret) m_retired = m_retired + 1'b1;
    m_trap = 0;
    if (flush) begin
      m_valid = 0; m_we = 0;
    end else if (take) begin
      m_valid = 1;
      m_addr  = da;
      case (md)
        2'b00:   m_data = fu_out;
        2'b01:   m_data = dmem_data;
        2'b10:   m_data = {31'd0, tb_slt};
        default: m_data = '0;
      endcase
      m_we   = rw && (da != 0) && (md != 2'b11) && !ovf;
      m_trap = ovf;
      if (fl) m_status = {fu_c, fu_v, fu_n, fu_z};
    end else if (ret) begin
      m_valid = 0; m_we = 0;
    end
    check_outputs(pfx);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs("rst_async");
    ex_valid = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("rst_rel");
    check("rst_ex_ready", ex_ready, 1);
  endtask

  logic [3:0]        saved_status;
  logic [DATA_W-1:0] bp_val;

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("init");
    check("init_ex_ready", ex_ready, 1);

    // Load an entry and hold it so reset hits an occupied slot.
    wb_ready = 0; ex_valid = 1; rw = 1; da = 5'd9; md = 2'b00; fl = 1;
    set_op(32'h1234, 32'h1, 0);
    step("preload");
    check("preload_valid_set", wb_valid, 1);
    do_reset();

    // Basic write: 0xA85 + 0x9493 = 0x9F18, flags all clear.
    wb_ready = 1; ex_valid = 1; rw = 1; da = 5'd3; md = 2'b00; fl = 1;
    set_op(32'h0000_0A85, 32'h0000_9493, 0);
    step("basic");
    check("basic_we", wb_we, 1);
    check("basic_data", wb_data, 32'h0000_9F18);
    check("basic_status", status, 4'b0000);

    // Destination R0 never writes, but still retires.
    da = 5'd0; set_op(32'h55, 32'h22, 0);
    step("r0");
    check("r0_we", wb_we, 0);
    check("r0_retired", retired, 1);

    // Set-less-than: 1 - 2 gives N=1, V=0 -> 1.
    da = 5'd4; md = 2'b10; set_op(32'd1, 32'd2, 1);
    step("slt");
    check("slt_data", wb_data, 32'h1);
    check("slt_retired", retired, 2);

    // Back-pressure: held entry must stay stable for three stalled cycles.
    bp_val = 32'h9492_5643;
    bp_val = bp_val >> 4;
    md = 2'b00; da = 5'd7; fu_out = bp_val;
    step("bp_load");
    wb_ready = 0; set_op(32'hDEAD_0000, 32'h0000_BEEF, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_stall");
      check("bp_hold", wb_data, 32'h0949_2564);
    end
    wb_ready = 1;
    step("bp_release");
    check("bp_next", wb_data, 32'hDEAD_BEEF);

    // Flush with flags 1111 must not touch status.
    saved_status = status;
    flush = 1; fl = 1; fu_c = 1; fu_v = 1; fu_n = 1; fu_z = 1;
    step("flush");
    check("flush_valid", wb_valid, 0);
    check("flush_status", status, saved_status);
    flush = 0;

    // Overflow: 0x7FFFFFFF + 1 sets V.
    da = 5'd5; md = 2'b00; rw = 1; set_op(32'h7FFF_FFFF, 32'h1, 0);
    step("ovf");
`ifdef OVF_TRAP_EN
    check("ovf_we", wb_we, 0);
    check("ovf_trap", trap, 1);
`else
    check("ovf_we", wb_we, 1);
    check("ovf_trap", trap, 0);
`endif
    ex_valid = 0;
    step("ovf_after");
    check("ovf_trap_gone", trap, 0);

    // Randomized traffic, with one asynchronous reset partway through.
    for (int i = 0; i < 3000; i++) begin
      bit sub;
      if (i == 1500) do_reset();
      ex_valid  = ($urandom_range(0, 3) != 0);
      wb_ready  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      md        = 2'($urandom_range(0, 3));
      rw        = ($urandom_range(0, 4) != 0);
      da        = ADDR_W'($urandom);
      fl        = $urandom_range(0, 1);
      dmem_data = $urandom;
      sub       = (md == 2'b10) || ($urandom_range(0, 1) == 1);
      set_op($urandom, $urandom, sub);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
